// File: rtl/cpu_program_loader.sv
// Boot sequencer: streams a program into byte-wide instruction memory, holds the CPU in
// reset through load and settle time, then runs it for an optional cycle budget.
module cpu_program_loader #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned RUN_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic [RUN_W-1:0]      run_cycles,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len,
    output logic [RUN_W-1:0]      cycle_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_STOP = 3'd4;

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]            state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [RUN_W-1:0]      run_len_q;
    logic [RUN_W-1:0]      cnt_q;
    logic [HW-1:0]         hold_q;
    logic                  err_q;

    logic len_ok;
    logic xfer;
    logic last_byte;
    logic idle_like;

    always_comb begin
        len_ok    = (prog_len != '0) && !prog_len[0] && (prog_len <= MAX_LEN);
        idle_like = (state_q == ST_IDLE) || (state_q == ST_STOP);
        in_ready  = (state_q == ST_LOAD);
        // Abort and reset suppress the write in the cycle they are seen.
        xfer      = in_ready && in_valid && !abort && !reset;
        last_byte = ({1'b0, ptr_q} == (len_q - 1'b1));
        mem_we    = xfer;
        mem_addr  = xfer ? ptr_q : '0;
        mem_wdata = xfer ? in_data : '0;
        cpu_reset = (state_q != ST_RUN);
        busy      = (state_q == ST_LOAD) || (state_q == ST_HOLD) || (state_q == ST_RUN);
        done      = (state_q == ST_STOP);
        err_len   = err_q;
        cycle_count = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            len_q     <= '0;
            run_len_q <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            err_q     <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_STOP: begin
                    if (start && len_ok) begin
                        state_q   <= ST_LOAD;
                        len_q     <= prog_len;
                        run_len_q <= run_cycles;
                        ptr_q     <= '0;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (last_byte) begin
                            hold_q  <= '0;
                            state_q <= (HOLD_CYCLES == 0) ? ST_RUN : ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= ST_RUN;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Budget of N leaves cycle_count at N with exactly N unreset cycles.
                    if ((run_len_q != '0) && (cnt_q == run_len_q - 1'b1)) begin
                        state_q <= ST_STOP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
